// File: rtl/mem_arbiter_pkg.sv
// Shared types and sizes for the memory arbiter slice: RAM word, RAM handshake state and arbiter FSM state.
package mem_arbiter_pkg;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DSERV = 2'd1,
    ISERV = 2'd2
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of icache, dcache and RAM signals around the arbiter; slave is the arbiter's view, master the caches'/RAM's view.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported RAM between icache (read) and dcache (read/write), dcache first, grant held per word.
// Define MEMARB_ISTARVE_EN to force an icache grant after STARVE_MAX consecutive dcache words.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  arb_state_t r_state;
  arb_state_t w_nextState;
  logic       w_dReq;
  logic       w_ramDone;
  logic       w_grantD;
  logic       w_grantI;
  logic       w_iStarved;

  assign w_dReq    = bus.dREN | bus.dWEN;
  assign w_ramDone = (bus.ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Grants are gated by nRST so an in-flight word is dropped the moment reset asserts.
  always_comb begin
    w_grantD    = 1'b0;
    w_grantI    = 1'b0;
    w_nextState = IDLE;
    case (r_state)
      IDLE: begin
        w_grantD = w_dReq & ~(w_iStarved & bus.iREN);
        w_grantI = bus.iREN & ~w_grantD;
      end
      DSERV:   w_grantD = w_dReq;
      ISERV:   w_grantI = bus.iREN;
      default: begin end
    endcase
    if (!nRST) begin
      w_grantD = 1'b0;
      w_grantI = 1'b0;
    end
    if (w_grantD && !w_ramDone)      w_nextState = DSERV;
    else if (w_grantI && !w_ramDone) w_nextState = ISERV;
  end

  assign bus.ramREN   = w_grantD ? (bus.dREN & ~bus.dWEN) : w_grantI;
  assign bus.ramWEN   = w_grantD & bus.dWEN;
  assign bus.ramaddr  = w_grantD ? bus.daddr : (w_grantI ? bus.iaddr : '0);
  assign bus.ramstore = (w_grantD && bus.dWEN) ? bus.dstore : '0;
  assign bus.dwait    = ~(w_grantD & w_ramDone);
  assign bus.iwait    = ~(w_grantI & w_ramDone);
  assign bus.dload    = bus.ramload;
  assign bus.iload    = bus.ramload;

`ifdef MEMARB_ISTARVE_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] r_starveCnt;
  logic             w_dDone;
  logic             w_iDone;

  assign w_dDone = w_grantD & w_ramDone;
  assign w_iDone = w_grantI & w_ramDone;

  // Counts dcache words completed while the icache is kept waiting; saturates at the limit.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                     r_starveCnt <= '0;
    else if (!bus.iREN || w_iDone) r_starveCnt <= '0;
    else if (w_dDone && (r_starveCnt != CNT_W'(STARVE_MAX)))
      r_starveCnt <= r_starveCnt + CNT_W'(1);
  end

  assign w_iStarved = (r_starveCnt == CNT_W'(STARVE_MAX));
`else
  assign w_iStarved = 1'b0;
`endif

endmodule
